// File: rtl/microsequencer_param_pkg.sv
// Shared sequencing-op encodings and helpers for the microprogram sequencer.
package useq_pkg;

  typedef logic [2:0] uop_t;

  localparam uop_t UOP_DEC  = 3'b000;
  localparam uop_t UOP_INC  = 3'b001;
  localparam uop_t UOP_JMP  = 3'b010;
  localparam uop_t UOP_CJMP = 3'b011;
  localparam uop_t UOP_CDEC = 3'b100;
  localparam uop_t UOP_CALL = 3'b101;
  localparam uop_t UOP_RET  = 3'b110;
  localparam uop_t UOP_WAIT = 3'b111;

  // Width of the condition-select field; a single condition still needs one bit.
  function automatic int csw_of(input int ncond);
    return (ncond <= 1) ? 1 : $clog2(ncond);
  endfunction

endpackage

// File: rtl/microsequencer_param_if.sv
// Microword sequencing fields in, current/next microaddress out.
interface microsequencer_param_if #(
   parameter int AW    = 7,
   parameter int NCOND = 4
);
   import useq_pkg::*;
   localparam int CSW = csw_of(NCOND);

   uop_t             uop;
   logic [CSW-1:0]   cond_sel;
   logic             cond_inv;
   logic [AW-1:0]    cr;
   logic [AW-1:0]    dec_addr;
   logic [NCOND-1:0] cond_in;
   logic [AW-1:0]    upc;
   logic [AW-1:0]    next_upc;

   // No handshake: the microword is consumed every unstalled cycle.
   modport master (output uop, cond_sel, cond_inv, cr, dec_addr, cond_in,
                   input  upc, next_upc);
   modport slave  (input  uop, cond_sel, cond_inv, cr, dec_addr, cond_in,
                   output upc, next_upc);
endinterface

// File: rtl/microsequencer_param_ret_stack.sv
// Return-address stack for CALL/RET; illegal push (full) or pop (empty) is ignored.
module useq_ret_stack #(
   parameter int AW          = 7,
   parameter int STACK_DEPTH = 2
) (
   input  logic                                 Clk,
   input  logic                                 Clr,
   input  logic                                 push,
   input  logic                                 pop,
   input  logic [AW-1:0]                        din,
   output logic [AW-1:0]                        top,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
   output logic                                 full,
   output logic                                 empty
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [AW-1:0] mem [STACK_DEPTH];
   logic [DW-1:0] depth_m1;

   assign full     = (depth == DW'(STACK_DEPTH));
   assign empty    = (depth == '0);
   assign depth_m1 = depth - DW'(1);
   assign top      = empty ? '0 : mem[depth_m1[IW-1:0]];

   always_ff @(posedge Clk) begin
      if (Clr)
         depth <= '0;
      else if (push && !full)
         depth <= depth + DW'(1);
      else if (pop && !empty)
         depth <= depth_m1;
   end

   // Entries need no reset: only slots below depth are ever read.
   always_ff @(posedge Clk) begin
      if (!Clr && push && !full)
         mem[depth[IW-1:0]] <= din;
   end
endmodule

// File: rtl/microsequencer_param.sv
// Microprogram sequencer: next-address mux, condition select, upc and stack error flag.
// Optional breakpoint logic is built when USEQ_BREAKPOINT_EN is defined.
module microsequencer_param
   import useq_pkg::*;
#(
   parameter int          AW          = 7,
   parameter int          NCOND       = 4,
   parameter int          STACK_DEPTH = 2,
   parameter int unsigned RESET_ADDR  = 1
) (
   input  logic                             Clk,
   input  logic                             Clr,
   input  logic                             stall,
`ifdef USEQ_BREAKPOINT_EN
   input  logic                             bp_en,
   input  logic [AW-1:0]                    bp_addr,
   input  logic                             resume,
   output logic                             bp_hit,
`endif
   output logic [$clog2(STACK_DEPTH+1)-1:0] stk_depth,
   output logic                             stk_err,
   microsequencer_param_if.slave            bus
);
   logic [AW-1:0] upc_q;
   logic [AW-1:0] inc;
   logic [AW-1:0] nxt;
   logic [AW-1:0] stk_top;
   logic          c;
   logic          hold;
   logic          is_call;
   logic          is_ret;
   logic          full;
   logic          empty;

   // Out-of-range selects read as a constant 0 before inversion.
   assign c   = ((int'(bus.cond_sel) < NCOND) ? bus.cond_in[bus.cond_sel] : 1'b0) ^ bus.cond_inv;
   assign inc = upc_q + AW'(1);

   always_comb begin
      nxt = inc;
      case (bus.uop)
         UOP_DEC:  nxt = bus.dec_addr;
         UOP_INC:  nxt = inc;
         UOP_JMP:  nxt = bus.cr;
         UOP_CJMP: nxt = c ? bus.cr : inc;
         UOP_CDEC: nxt = c ? bus.dec_addr : inc;
         UOP_CALL: nxt = bus.cr;
         UOP_RET:  nxt = empty ? AW'(RESET_ADDR) : stk_top;
         UOP_WAIT: nxt = c ? inc : upc_q;
         default:  nxt = inc;
      endcase
   end

`ifdef USEQ_BREAKPOINT_EN
   logic bp_hit_q;
   logic bp_armed;

   // resume lets this cycle's advance through even though bp_hit is still set.
   assign hold   = stall | (bp_hit_q & ~resume);
   assign bp_hit = bp_hit_q;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         bp_hit_q <= 1'b0;
         bp_armed <= 1'b1;
      end else begin
         if (bp_hit_q)
            bp_hit_q <= ~resume;
         else if (bp_en && bp_armed && (upc_q == bp_addr))
            bp_hit_q <= 1'b1;
         // After a resume the breakpoint stays disarmed until upc moves off it.
         if (bp_hit_q && resume)
            bp_armed <= 1'b0;
         else if (upc_q != bp_addr)
            bp_armed <= 1'b1;
      end
   end
`else
   assign hold = stall;
`endif

   assign is_call = (bus.uop == UOP_CALL);
   assign is_ret  = (bus.uop == UOP_RET);

   useq_ret_stack #(.AW(AW), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .Clk   (Clk),
      .Clr   (Clr),
      .push  (is_call && !hold),
      .pop   (is_ret && !hold),
      .din   (inc),
      .top   (stk_top),
      .depth (stk_depth),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge Clk) begin
      if (Clr) begin
         upc_q   <= AW'(RESET_ADDR);
         stk_err <= 1'b0;
      end else if (!hold) begin
         upc_q <= nxt;
         if ((is_call && full) || (is_ret && empty))
            stk_err <= 1'b1;
      end
   end

   assign bus.upc      = upc_q;
   assign bus.next_upc = nxt;
endmodule
